// File: rtl/mux8_tree_reg.sv
//============================================================================
// Module   : mux8_tree_reg (with helpers mux8_tree_reg_mux2, mux8_tree_reg_mux4)
// Purpose  : Registered 8:1 word selector built as a bit-sliced mux tree:
//            two 4:1 stages (words 0..3 and 4..7, select[1:0]) feed a 2:1
//            stage (select[2]), followed by an output register.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-high reset
//            in_valid     - qualifies input_bits/select_bits this cycle
//            input_bits   - eight packed words, word k = [k*WIDTH +: WIDTH]
//            select_bits  - index of the word to pass
//            output_bits  - registered selected word (holds when idle)
//            out_valid    - registered in_valid
//            comb_bits    - unregistered selected word, same cycle
// Options  : MUX_TREE_PIPE_EN - when defined, a pipeline register sits
//            between the 4:1 stages and the 2:1 stage (latency 2).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

// 2:1 primitive: o_y = i_s ? i_d1 : i_d0
module mux8_tree_reg_mux2 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_s,
    output logic o_y
);
    assign o_y = i_s ? i_d1 : i_d0;
endmodule

// 4:1 primitive built from three 2:1 stages; i_s[0] picks within pairs,
// i_s[1] picks between the pairs.
module mux8_tree_reg_mux4 (
    input  logic       i_d0,
    input  logic       i_d1,
    input  logic       i_d2,
    input  logic       i_d3,
    input  logic [1:0] i_s,
    output logic       o_y
);
    logic w_p01;
    logic w_p23;

    mux8_tree_reg_mux2 u_m01 (.i_d0(i_d0),  .i_d1(i_d1),  .i_s(i_s[0]), .o_y(w_p01));
    mux8_tree_reg_mux2 u_m23 (.i_d0(i_d2),  .i_d1(i_d3),  .i_s(i_s[0]), .o_y(w_p23));
    mux8_tree_reg_mux2 u_mo  (.i_d0(w_p01), .i_d1(w_p23), .i_s(i_s[1]), .o_y(o_y));
endmodule

module mux8_tree_reg #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [8*WIDTH-1:0] input_bits,
    input  logic [2:0]         select_bits,
    output logic [WIDTH-1:0]   output_bits,
    output logic               out_valid,
    output logic [WIDTH-1:0]   comb_bits
);

    logic [WIDTH-1:0] w_lo;          // words 0..3 stage
    logic [WIDTH-1:0] w_hi;          // words 4..7 stage
    logic [WIDTH-1:0] w_sel;         // unpipelined 2:1 result
    logic [WIDTH-1:0] w_stage_data;  // data presented to the output register
    logic             w_stage_valid; // valid presented to the output register
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            mux8_tree_reg_mux4 u_lo (
                .i_d0 (input_bits[0*WIDTH+b]),
                .i_d1 (input_bits[1*WIDTH+b]),
                .i_d2 (input_bits[2*WIDTH+b]),
                .i_d3 (input_bits[3*WIDTH+b]),
                .i_s  (select_bits[1:0]),
                .o_y  (w_lo[b])
            );
            mux8_tree_reg_mux4 u_hi (
                .i_d0 (input_bits[4*WIDTH+b]),
                .i_d1 (input_bits[5*WIDTH+b]),
                .i_d2 (input_bits[6*WIDTH+b]),
                .i_d3 (input_bits[7*WIDTH+b]),
                .i_s  (select_bits[1:0]),
                .o_y  (w_hi[b])
            );
            mux8_tree_reg_mux2 u_top (
                .i_d0 (w_lo[b]),
                .i_d1 (w_hi[b]),
                .i_s  (select_bits[2]),
                .o_y  (w_sel[b])
            );
        end
    endgenerate

    // comb_bits always comes from the unpipelined tree, in either build.
    assign comb_bits = w_sel;

`ifdef MUX_TREE_PIPE_EN
    // Pipeline register between the 4:1 stages and the final 2:1 stage.
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_sel2;
    logic             r_pipe_valid;
    logic [WIDTH-1:0] w_pipe_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo         <= '0;
            r_hi         <= '0;
            r_sel2       <= 1'b0;
            r_pipe_valid <= 1'b0;
        end else begin
            r_lo         <= w_lo;
            r_hi         <= w_hi;
            r_sel2       <= select_bits[2];
            r_pipe_valid <= in_valid;
        end
    end

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_pipe_bit
            mux8_tree_reg_mux2 u_pipe_top (
                .i_d0 (r_lo[b]),
                .i_d1 (r_hi[b]),
                .i_s  (r_sel2),
                .o_y  (w_pipe_sel[b])
            );
        end
    endgenerate

    assign w_stage_data  = w_pipe_sel;
    assign w_stage_valid = r_pipe_valid;
`else
    assign w_stage_data  = w_sel;
    assign w_stage_valid = in_valid;
`endif

    // Output register: data only loads on a valid beat, otherwise it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_stage_valid;
            if (w_stage_valid) begin
                r_out <= w_stage_data;
            end
        end
    end

    assign output_bits = r_out;
    assign out_valid   = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux8_tree_reg.sv
//============================================================================
// Module   : tb_mux8_tree_reg
// Purpose  : Self-checking bench for mux8_tree_reg at WIDTH = 1, 8 and 4.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mux8_tree_reg;

`ifdef MUX_TREE_PIPE_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 1;
`endif
    localparam int c_nrand = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic        v1;
    logic [7:0]  b1;
    logic [2:0]  s1;
    logic        o1, ov1, c1;
    // WIDTH = 8 instance
    logic        v8;
    logic [63:0] b8;
    logic [2:0]  s8;
    logic [7:0]  o8, c8;
    logic        ov8;
    // WIDTH = 4 instance
    logic        v4;
    logic [31:0] b4;
    logic [2:0]  s4;
    logic [3:0]  o4, c4;
    logic        ov4;

    mux8_tree_reg #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .input_bits(b1), .select_bits(s1),
        .output_bits(o1), .out_valid(ov1), .comb_bits(c1));
    mux8_tree_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .input_bits(b8), .select_bits(s8),
        .output_bits(o8), .out_valid(ov8), .comb_bits(c8));
    mux8_tree_reg #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .input_bits(b4), .select_bits(s4),
        .output_bits(o4), .out_valid(ov4), .comb_bits(c4));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          w8;
        logic [63:0] bits;
        logic [2:0]  sel;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[16];

    task automatic drive_vec(input vec_t v, input logic valid);
        if (v.w8) begin
            v8 = valid; b8 = v.bits; s8 = v.sel;
        end else begin
            v1 = valid; b1 = v.bits[7:0]; s1 = v.sel;
        end
    endtask

    function automatic logic [7:0] out_of(input bit w8);
        return w8 ? o8 : {7'b0, o1};
    endfunction
    function automatic logic [7:0] comb_of(input bit w8);
        return w8 ? c8 : {7'b0, c1};
    endfunction
    function automatic logic vld_of(input bit w8);
        return w8 ? ov8 : ov1;
    endfunction

    // Stream a table segment back-to-back, checking comb_bits in-cycle and
    // output_bits/out_valid c_lat edges after each vector was presented.
    task automatic run_seg(input int first, input int n);
        bit w8;
        w8 = tbl[first].w8;
        for (int i = 0; i < n + c_lat - 1; i++) begin
            int k;
            if (i < n) drive_vec(tbl[first+i], 1'b1);
            else       drive_vec(tbl[first], 1'b0);
            #1;
            if (i < n) check("comb_seq", comb_of(w8), tbl[first+i].exp);
            tick();
            k = i - c_lat + 1;
            if (k >= 0 && k < n) begin
                check("out_seq", out_of(w8), tbl[first+k].exp);
                check("vld_seq", vld_of(w8), 1);
            end
        end
        drive_vec(tbl[first], 1'b0);
    endtask

    logic        hv[c_nrand];
    logic [3:0]  hw[c_nrand];

    initial begin
        // Table: WIDTH=1 alternating sweep, then WIDTH=8 one-hot walk.
        for (int k = 0; k < 8; k++) begin
            tbl[k].w8   = 1'b0;
            tbl[k].bits = 64'h00000000000000AA;
            tbl[k].sel  = 3'(k);
            tbl[k].exp  = 8'(k % 2);
            tbl[8+k].w8   = 1'b1;
            tbl[8+k].bits = 64'h8040201008040201;
            tbl[8+k].sel  = 3'(k);
            tbl[8+k].exp  = 8'(1 << k);
        end

        // Reset held with valid traffic present.
        reset = 1'b1;
        v1 = 1'b1; b1 = 8'hFF; s1 = 3'd1;
        v8 = 1'b1; b8 = '1;    s8 = 3'd6;
        v4 = 1'b0; b4 = '0;    s4 = 3'd0;
        for (int r = 0; r < 2; r++) begin
            tick();
            check("rst_out1", o1, 0);
            check("rst_vld1", ov1, 0);
            check("rst_out8", o8, 0);
            check("rst_vld8", ov8, 0);
        end
        check("rst_comb1", c1, 1);
        check("rst_comb8", c8, 8'hFF);
        reset = 1'b0;
        v1 = 1'b0; v8 = 1'b0;
        repeat (2) tick();

        run_seg(0, 8);
        run_seg(8, 8);

        // Hold: capture word 5, then idle with changing inputs.
        v8 = 1'b1; b8 = 64'h8040201008040201; s8 = 3'd5;
        tick();
        v8 = 1'b0; b8 = 64'h0123456789ABCDEF; s8 = 3'd2;
        repeat (c_lat - 1) tick();
        check("hold_cap", o8, 8'h20);
        check("hold_cap_vld", ov8, 1);
        repeat (2) begin
            s8 = s8 + 3'd3;
            tick();
            check("hold_out", o8, 8'h20);
            check("hold_vld", ov8, 0);
        end

        // Reset mid-stream drops the coincident transaction.
        reset = 1'b1;
        v8 = 1'b1; b8 = 64'h8040201008040201; s8 = 3'd7;
        tick();
        check("mid_rst_out", o8, 0);
        check("mid_rst_vld", ov8, 0);
        reset = 1'b0;
        s8 = 3'd3;
        tick();
        v8 = 1'b0; s8 = 3'd7;
        for (int k = 1; k <= c_lat; k++) begin
            if (k > 1) tick();
            check("post_rst_out", o8, (k == c_lat) ? 8'h08 : 8'h00);
            check("post_rst_vld", ov8, (k == c_lat) ? 1 : 0);
        end
        tick();
        check("post_rst_hold", o8, 8'h08);
        check("post_rst_idle", ov8, 0);

        // Random regression on WIDTH=4 against a word-indexing model.
        begin
            logic [3:0] model_out;
            model_out = '0;
            for (int t = 0; t < c_nrand; t++) begin
                int idx;
                v4 = 1'($urandom_range(0, 3) != 0);
                b4 = $urandom;
                s4 = 3'($urandom_range(0, 7));
                hv[t] = v4;
                hw[t] = 4'((b4 >> (32'(s4) * 4)) & 32'hF);
                #1;
                check("rnd_comb", c4, hw[t]);
                tick();
                idx = t - c_lat + 1;
                if (idx >= 0 && hv[idx]) model_out = hw[idx];
                check("rnd_out", o4, model_out);
                check("rnd_vld", ov4, (idx >= 0) ? hv[idx] : 1'b0);
            end
            v4 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux8_tree_reg.md
Name: mux8_tree_reg

Overview:
- Registered 8:1 selector built as a tree of 2:1 and 4:1 multiplexer stages, bit-sliced over a WIDTH-bit data word.
- Used in the 64-bit ARM datapath wherever one of eight candidate values is picked by a 3-bit code, e.g. register-read or flag selection.
- Structure:
  - Two 4:1 stages, each selected by select_bits[1:0].
  - One 2:1 stage, selected by select_bits[2].
  - One output register stage.

Parameters:
- WIDTH, default 1: bits per input word and width of the output word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies input_bits/select_bits in this cycle.
- input_bits  input  8*WIDTH  eight packed words; word k = input_bits[k*WIDTH +: WIDTH], k=0..7.
- select_bits  input  3  index of the word to pass.
- output_bits  output  WIDTH  registered selected word.
- out_valid  output  1  registered in_valid; high when output_bits holds a new result.
- comb_bits  output  WIDTH  unregistered selected word, same cycle as inputs.

Behaviour:
- Selection function, per bit b in 0..WIDTH-1:
  - Low 4:1 stage: lo[b] = word[select_bits[1:0]][b], drawing from words 0..3.
  - High 4:1 stage: hi[b] = word[4+select_bits[1:0]][b], drawing from words 4..7.
  - 2:1 stage: sel_out[b] = select_bits[2] ? hi[b] : lo[b].
  - Net result: sel_out = word[select_bits].
- comb_bits = sel_out. It is purely combinational, has no dependence on clk or reset, and is valid for any select_bits value.
- Register stage, on rising clk:
  - reset=1: output_bits <= 0, out_valid <= 0. Reset has priority over in_valid.
  - reset=0, in_valid=1: output_bits <= sel_out, out_valid <= 1.
  - reset=0, in_valid=0: output_bits holds its previous value, out_valid <= 0.
- Latency: 1 cycle from in_valid to out_valid/output_bits. Throughput: one selection per cycle, with no stall or backpressure.
- All 8 select codes are legal; no wrap or overflow is possible.
- Reset mid-stream: a transaction presented in the same cycle as reset is dropped. After reset deasserts, the next valid transaction appears one cycle later.
- X/undefined select_bits is outside the contract. RTL must not generate latches.
- Implementation is structural: instantiate 2:1 and 4:1 primitives (4:1 may itself be built from three 2:1 stages) for each bit slice using a generate loop.

Optional Feature:
- Macro: MUX_TREE_PIPE_EN.
- Defined:
  - Adds a pipeline register after the two 4:1 stages that captures lo, hi, select_bits[2] and in_valid. It resets synchronously to 0.
  - The 2:1 stage feeds the output register, so latency becomes 2 cycles. out_valid tracks in_valid delayed by 2.
  - comb_bits is still taken from the unpipelined path and stays combinational.
- Undefined: single register stage, latency 1, exactly as in Behaviour.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with in_valid=1 → output_bits=0 and out_valid=0 on every edge while reset is high.
2. Select sweep, WIDTH=1: input_bits=8'b10101010, in_valid=1, select_bits stepping 0..7 one value per cycle.
   - comb_bits = 0,1,0,1,0,1,0,1 in the same cycle.
   - output_bits shows the same sequence one cycle later (two cycles later with MUX_TREE_PIPE_EN), with out_valid=1.
3. One-hot walk, WIDTH=8: word k = 8'h01<<k. Sweep select_bits 0..7 → output_bits = 8'h01,8'h02,...,8'h80. This proves 4:1 half selection versus 2:1 MSB ordering.
4. Hold: capture select_bits=5 (value 8'h20), then set in_valid=0 and change input_bits/select_bits → output_bits stays 8'h20, out_valid=0.
5. Reset mid-stream: in_valid=1 with select_bits=7 in the same cycle as reset=1 → output_bits=0 and out_valid=0. The next valid select_bits=3 after reset deasserts yields word 3 with the configured latency.
6. Random regression: 1000 random input_bits/select_bits/in_valid vectors, WIDTH=4 → output_bits equals the model word[select_bits] delayed by the configured latency; comb_bits equals word[select_bits] with zero latency.
